// File: rtl/priority_arb_n_v_pkg.sv
// Shared constants for the N-way priority/round-robin arbiter: mode selectors and FSM states.
// Pure declarations, no logic; imported by the top and the selector.
package priority_arb_n_v_pkg;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/priority_sel_n_v.sv
// Combinational N-to-W selector: first set bit searching downward from start, wrapping N-1 after 0.
// Zero latency; no flow control, pure function of req and start.
module priority_sel_n_v
  import priority_arb_n_v_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         hit,
  output logic [W-1:0] code
);

  int idx;

  // Rotated position j maps to original index (start + j + 1) mod N, so j = N-1 is start itself.
  // Scanning j upward and keeping the last hit priority-encodes the rotated vector and un-rotates it.
  always_comb begin
    hit  = 1'b0;
    code = '0;
    idx  = 0;
    for (int j = 0; j < N; j++) begin
      idx = int'(start) + j + 1;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        hit  = 1'b1;
        code = W'(idx);
      end
    end
  end

endmodule

// File: rtl/priority_arb_n_v.sv
// Registered N-way arbiter: one grant per cycle, 1-cycle request-to-valid latency.
// Grant is held frozen until i_ack; requests arriving meanwhile wait, no preemption.
module priority_arb_n_v
  import priority_arb_n_v_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int RR_MODE = PRI_FIXED
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_ack,
  output logic         o_valid,
  output logic [W-1:0] o_code,
  output logic [N-1:0] o_grant,
  output logic         o_none
);

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   code_q, code_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           none_q, none_d;
  logic           ack_go;
  logic           sel_hit;
  logic [W-1:0]   sel_code;
  logic [W-1:0]   start;

  assign ack_go = (state_q == ST_GRANT) && i_ack;

  // The pointer moves on the ack edge and the re-evaluation in that same edge already sees it.
  assign ptr_d = ((RR_MODE == PRI_RR) && ack_go) ? code_q : ptr_q;

  always_comb begin
    start = W'(N - 1);
    if ((RR_MODE == PRI_RR) && (ptr_d != '0)) start = ptr_d - W'(1);
  end

  priority_sel_n_v #(
    .N (N),
    .W (W)
  ) u_sel (
    .req   (i_req),
    .start (start),
    .hit   (sel_hit),
    .code  (sel_code)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    grant_d = grant_q;
    none_d  = none_q;
    if ((state_q == ST_IDLE) || ack_go) begin
      none_d  = ~|i_req;
      grant_d = '0;
      if (sel_hit) begin
        state_d           = ST_GRANT;
        code_d            = sel_code;
        grant_d[sel_code] = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      code_q  <= '0;
      grant_q <= '0;
      none_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      none_q  <= none_d;
    end
  end

  assign o_valid = (state_q == ST_GRANT);
  assign o_code  = code_q;
  assign o_grant = grant_q;
  assign o_none  = none_q;

endmodule
